// File: rtl/mac_ctrl_pkg.sv
// Shared types and widths for the MAC sequencing controller.
package mac_ctrl_pkg;
  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/mac.sv
// Combinational signed multiply-accumulate; the product is also tapped out
// so the caller can judge accumulate overflow from operand signs.
module mac
  import mac_ctrl_pkg::*;
(
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [ACC_W-1:0] prod,
  output logic signed [ACC_W-1:0] acc_out
);
  // 8x8 signed product always fits in 16 bits, including -128*-128.
  assign prod    = ACC_W'(a) * ACC_W'(b);
  assign acc_out = acc_in + prod;
endmodule

// File: rtl/mac_seq_ctrl.sv
// Streams operand pairs through one shared mac into a 16-bit accumulator
// and hands the wrapped dot product plus a sticky overflow flag downstream.
//
// state  | meaning
// S_IDLE | waiting for start; result shows last accumulator value
// S_RUN  | accepting operand beats until len_q pairs are consumed
// S_HOLD | result presented with res_valid until res_ready
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         a_in,
  input  logic [OP_W-1:0]         b_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACC_W-1:0]        result,
  output logic                    ovf
);
  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_out, prod;
  logic [LEN_W-1:0]        cnt, len_q;
  logic                    accept_start, beat, last_beat, ovf_step;

  mac u_mac (
    .a       (a_in),
    .b       (b_in),
    .acc_in  (acc),
    .prod    (prod),
    .acc_out (acc_out)
  );

  assign accept_start = (state == S_IDLE) && start;
  assign beat         = (state == S_RUN) && in_valid;
  assign last_beat    = beat && (cnt == len_q - LEN_W'(1));
  // Same-sign operands whose sum flips sign is a signed overflow.
  assign ovf_step     = (prod[ACC_W-1] == acc[ACC_W-1]) &&
                        (acc_out[ACC_W-1] != acc[ACC_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_HOLD : S_RUN;
      S_RUN:  if (last_beat) state_nxt = S_HOLD;
      S_HOLD: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (accept_start) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= len;
      ovf   <= 1'b0;
    end else if (beat) begin
      acc <= acc_out;
      cnt <= cnt + LEN_W'(1);
      if (ovf_step) ovf <= 1'b1;
    end
  end

  assign busy      = (state == S_RUN) || (state == S_HOLD);
  assign in_ready  = (state == S_RUN);
  assign res_valid = (state == S_HOLD);
  assign result    = acc;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: expected results are queued when a job
// is launched and popped when the controller presents its result.
module tb_mac_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        ovf;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   a_list[$];
  int   b_list[$];
  int   tests  = 0;
  int   failed = 0;

  mac_seq_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a job of n pairs from a_list/b_list; vpat bit c gates in_valid in
  // cycle c after start. Returns the cycle count at which res_valid appeared.
  task automatic run_job(input int n, input logic [15:0] vpat,
                         input logic [15:0] exp_res, input logic exp_ovf,
                         output int lat);
    exp_t e;
    int   i, k;
    logic v, hs;
    e.res = exp_res;
    e.ovf = exp_ovf;
    sb.push_back(e);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    k = 1;
    i = 0;
    if (n != 0) begin
      check("busy_after_start", busy, 1);
      check("in_ready_after_start", in_ready, 1);
      check("ovf_cleared_by_start", ovf, 0);
    end
    while (!res_valid && k < 200) begin
      v        = (i < n) ? vpat[(k - 1) % 16] : 1'b0;
      in_valid = v;
      a_in     = (i < n) ? 8'(a_list[i]) : 8'h00;
      b_in     = (i < n) ? 8'(b_list[i]) : 8'h00;
      hs       = v && in_ready;
      tick();
      k++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    lat = k;
    check("res_valid_within_bound", res_valid, 1);
    check("beats_consumed", i, n);
    e = sb.pop_front();
    check("result", result, e.res);
    check("ovf", ovf, e.ovf);
    a_list.delete();
    b_list.delete();
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("busy_drop", busy, 0);
  endtask

  int lat;
  logic [15:0] held;

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic dot product, in_valid held high: 6 - 20 - 7 = -21
    a_list = '{2, -4, 7};
    b_list = '{3, 5, -1};
    run_job(3, 16'hFFFF, 16'hFFEB, 1'b0, lat);
    check("latency_len3", lat, 4);
    release_result();

    // Gaps in in_valid must not count as beats
    a_list = '{1, 1, 1, 1};
    b_list = '{1, 1, 1, 1};
    run_job(4, 16'h0059, 16'd4, 1'b0, lat);
    check("latency_gapped", lat, 8);
    release_result();

    // Wrap-around with sticky overflow
    a_list = '{-128, -128, -128};
    b_list = '{-128, -128, -128};
    run_job(3, 16'hFFFF, 16'hC000, 1'b1, lat);
    release_result();

    // Zero-length job goes straight to HOLD; start during HOLD ignored
    run_job(0, 16'hFFFF, 16'h0000, 1'b0, lat);
    check("latency_len0", lat, 1);
    check("len0_busy", busy, 1);
    check("len0_ovf_cleared", ovf, 0);
    held = result;
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      len   = 8'd3;
      tick();
      check("hold_res_valid", res_valid, 1);
      check("hold_result", result, held);
      check("hold_in_ready", in_ready, 0);
    end
    start = 1'b0;
    release_result();

    // Back-to-back: second job starts right after the release edge
    a_list = '{10, 10};
    b_list = '{10, 10};
    run_job(2, 16'hFFFF, 16'd200, 1'b0, lat);
    release_result();
    a_list = '{5, -2};
    b_list = '{6, 3};
    run_job(2, 16'hFFFF, 16'd24, 1'b0, lat);
    release_result();

    // Asynchronous reset in the middle of a 5-beat job
    start = 1'b1;
    len   = 8'd5;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    a_in     = 8'd9;
    b_in     = 8'd9;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_ovf", ovf, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);
    a_list = '{3, 1};
    b_list = '{3, 1};
    run_job(2, 16'hFFFF, 16'd10, 1'b0, lat);
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
